// File: rtl/alu_writeback_ctrl.sv
// alu_writeback_ctrl: consumer end of the ALU result interface.
// MULT/DIV results load HI/LO directly. Other results with a non-zero destination queue in a
// circular FIFO that drains to the register-file write port under an rf_ready handshake.
// The block also keeps a flags register and a sticky overflow bit.
module alu_writeback_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               FS,
  input  logic [AW-1:0]            dest,
  input  logic [31:0]              Y_hi,
  input  logic [31:0]              Y_lo,
  input  logic                     N,
  input  logic                     Z,
  input  logic                     C,
  input  logic                     V,
  output logic [31:0]              HI,
  output logic [31:0]              LO,
  output logic [3:0]               flags,
  output logic                     ovf_sticky,
  input  logic                     ovf_clr,
  output logic                     wr_en,
  output logic [AW-1:0]            wr_addr,
  output logic [31:0]              wr_data,
  input  logic                     rf_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [4:0] FS_MULT = 5'h1E;
  localparam logic [4:0] FS_DIV  = 5'h1F;

  logic [31:0]    hi_q, hi_d;
  logic [31:0]    lo_q, lo_d;
  logic [3:0]     flags_q, flags_d;
  logic           ovf_q, ovf_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [AW-1:0]  addr_mem [DEPTH];
  logic [31:0]    data_mem [DEPTH];

  logic accept, hilo_op, push, pop, empty, full;

  // Handshake decode; occupancy flags come straight from the registered count.
  always_comb begin
    empty    = (count_q == CW'(0));
    full     = (count_q == CW'(DEPTH));
    accept   = in_valid & ~full;
    hilo_op  = (FS == FS_MULT) || (FS == FS_DIV);
    push     = accept & ~hilo_op & (dest != AW'(0));
    pop      = ~empty & rf_ready;
  end

  // Next-state for HI/LO, flags, sticky overflow, pointers and occupancy.
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    flags_d  = flags_q;
    ovf_d    = ovf_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (accept) begin
      if (hilo_op) begin
        hi_d         = Y_hi;
        lo_d         = Y_lo;
        flags_d[3:2] = {N, Z};
      end else begin
        flags_d = {N, Z, C, V};
        if (V) ovf_d = 1'b1;
      end
    end
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  // State registers; reset flushes the queue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q     <= '0;
      lo_q     <= '0;
      flags_q  <= '0;
      ovf_q    <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      flags_q  <= flags_d;
      ovf_q    <= ovf_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only visible through the non-empty mask below.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= dest;
      data_mem[wr_ptr_q] <= Y_lo;
    end
  end

  // Output view: head entry when non-empty, zero otherwise.
  always_comb begin
    in_ready   = ~full;
    wr_en      = ~empty;
    wr_addr    = empty ? AW'(0) : addr_mem[rd_ptr_q];
    wr_data    = empty ? 32'h0 : data_mem[rd_ptr_q];
    HI         = hi_q;
    LO         = lo_q;
    flags      = flags_q;
    ovf_sticky = ovf_q;
    count      = count_q;
  end

endmodule

// File: tb/tb_alu_writeback_ctrl.sv
// Directed bench for alu_writeback_ctrl with hand-computed expectations.
module tb_alu_writeback_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  FS;
  logic [4:0]  dest;
  logic [31:0] Y_hi, Y_lo;
  logic        N, Z, C, V;
  logic [31:0] HI, LO;
  logic [3:0]  flags;
  logic        ovf_sticky;
  logic        ovf_clr;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rf_ready;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  alu_writeback_ctrl #(.DEPTH(4), .AW(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .FS(FS),
    .dest(dest), .Y_hi(Y_hi), .Y_lo(Y_lo), .N(N), .Z(Z), .C(C), .V(V),
    .HI(HI), .LO(LO), .flags(flags), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rf_ready(rf_ready), .count(count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] fs, input logic [4:0] d,
                       input logic [31:0] yh, input logic [31:0] yl, input logic [3:0] nzcv);
    in_valid = v; FS = fs; dest = d; Y_hi = yh; Y_lo = yl;
    {N, Z, C, V} = nzcv;
  endtask

  task automatic idle();
    drive(1'b0, 5'h00, 5'd0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic test_reset();
    reset = 1'b1; ovf_clr = 1'b0; rf_ready = 1'b0; idle();
    #12;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
    reset = 1'b0;
    step();
    total++; if (HI !== 32'h0 || LO !== 32'h0) begin bad++; $display("FAIL rst_hilo got=%h/%h exp=0/0", HI, LO); end
    total++; if (flags !== 4'h0 || ovf_sticky !== 1'b0) begin bad++; $display("FAIL rst_flags got=%h/%b exp=0/0", flags, ovf_sticky); end
    total++; if (count !== 3'd0 || wr_en !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL rst_fifo count=%0d wr_en=%b in_ready=%b exp=0/0/1", count, wr_en, in_ready); end
    total++; if (wr_addr !== 5'd0 || wr_data !== 32'h0) begin bad++; $display("FAIL rst_head got=%0d/%h exp=0/0", wr_addr, wr_data); end
  endtask

  task automatic test_mult_div();
    // Prime flags C,V with a dropped dest-0 op, then MULT must hold them.
    drive(1'b1, 5'h02, 5'd0, 32'h0, 32'h5, 4'b0011); step();
    total++; if (flags !== 4'b0011 || ovf_sticky !== 1'b1) begin bad++; $display("FAIL prime_flags got=%b/%b exp=0011/1", flags, ovf_sticky); end
    drive(1'b1, 5'h1E, 5'd7, 32'h1, 32'hFFFF_FFFE, 4'b0000); step();
    idle();
    total++; if (HI !== 32'h1 || LO !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mult_hilo got=%h/%h exp=00000001/fffffffe", HI, LO); end
    total++; if (count !== 3'd0 || flags !== 4'b0011) begin bad++; $display("FAIL mult_noq count=%0d flags=%b exp=0/0011", count, flags); end
    drive(1'b1, 5'h1F, 5'd3, 32'hAAAA_0000, 32'h0000_5555, 4'b1100); step();
    idle();
    total++; if (HI !== 32'hAAAA_0000 || LO !== 32'h0000_5555 || flags !== 4'b1111 || count !== 3'd0) begin
      bad++; $display("FAIL div_hilo got=%h/%h flags=%b count=%0d exp=aaaa0000/00005555/1111/0", HI, LO, flags, count); end
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    total++; if (ovf_sticky !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", ovf_sticky); end
  endtask

  task automatic test_fill_drain();
    rf_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'h02, 5'(i + 1), 32'h0, 32'(10 + i), 4'b0000); step();
    end
    total++; if (count !== 3'd4 || in_ready !== 1'b0) begin bad++; $display("FAIL full count=%0d in_ready=%b exp=4/0", count, in_ready); end
    drive(1'b1, 5'h02, 5'd5, 32'h0, 32'd99, 4'b0000); step();
    idle();
    total++; if (count !== 3'd4 || wr_addr !== 5'd1 || wr_data !== 32'd10 || wr_en !== 1'b1) begin
      bad++; $display("FAIL full_hold count=%0d head=%0d/%0d wr_en=%b exp=4/1/10/1", count, wr_addr, wr_data, wr_en); end
    rf_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      total++; if (wr_en !== 1'b1 || wr_addr !== 5'(k + 1) || wr_data !== 32'(10 + k)) begin
        bad++; $display("FAIL drain%0d got=%b/%0d/%0d exp=1/%0d/%0d", k, wr_en, wr_addr, wr_data, k + 1, 10 + k); end
      step();
      if (k == 0) begin
        total++; if (in_ready !== 1'b1 || count !== 3'd3) begin bad++; $display("FAIL unfull in_ready=%b count=%0d exp=1/3", in_ready, count); end
      end
    end
    rf_ready = 1'b0;
    total++; if (count !== 3'd0 || wr_en !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 32'h0) begin
      bad++; $display("FAIL drained count=%0d wr=%b/%0d/%h exp=0/0/0/0", count, wr_en, wr_addr, wr_data); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  qa[$];
    logic [31:0] qd[$];
    rf_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 5'h00, 5'(i + 1), 32'h0, 32'(100 + i), 4'b0000); step();
      qa.push_back(5'(i + 1)); qd.push_back(32'(100 + i));
    end
    total++; if (wr_addr !== 5'd1 || wr_data !== 32'd100) begin bad++; $display("FAIL b2b_latency got=%0d/%0d exp=1/100", wr_addr, wr_data); end
    rf_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 5'h00, 5'(i + 3), 32'h0, 32'(102 + i), 4'b0000);
      total++; if (wr_addr !== qa[0] || wr_data !== qd[0]) begin
        bad++; $display("FAIL b2b_head%0d got=%0d/%0d exp=%0d/%0d", i, wr_addr, wr_data, qa[0], qd[0]); end
      step();
      void'(qa.pop_front()); void'(qd.pop_front());
      qa.push_back(5'(i + 3)); qd.push_back(32'(102 + i));
      total++; if (count !== 3'd2) begin bad++; $display("FAIL b2b_count%0d got=%0d exp=2", i, count); end
    end
    idle();
    for (int i = 0; i < 2; i++) begin
      total++; if (wr_addr !== qa[0] || wr_data !== qd[0]) begin
        bad++; $display("FAIL b2b_tail%0d got=%0d/%0d exp=%0d/%0d", i, wr_addr, wr_data, qa[0], qd[0]); end
      step();
      void'(qa.pop_front()); void'(qd.pop_front());
    end
    rf_ready = 1'b0;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL b2b_empty got=%0d exp=0", count); end
  endtask

  task automatic test_dest0();
    drive(1'b1, 5'h02, 5'd0, 32'h0, 32'hDEAD, 4'b1010); step();
    idle();
    total++; if (count !== 3'd0 || wr_en !== 1'b0 || flags !== 4'b1010) begin
      bad++; $display("FAIL dest0 count=%0d wr_en=%b flags=%b exp=0/0/1010", count, wr_en, flags); end
  endtask

  task automatic test_ovf();
    ovf_clr = 1'b1;
    drive(1'b1, 5'h02, 5'd0, 32'h0, 32'h1, 4'b0001); step();
    idle();
    total++; if (ovf_sticky !== 1'b1) begin bad++; $display("FAIL ovf_set_prio got=%b exp=1", ovf_sticky); end
    step();
    ovf_clr = 1'b0;
    total++; if (ovf_sticky !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", ovf_sticky); end
    drive(1'b1, 5'h1F, 5'd0, 32'h1234, 32'h5678, 4'b1011); step();
    idle();
    total++; if (ovf_sticky !== 1'b0 || flags !== 4'b1001) begin
      bad++; $display("FAIL div_ovf got=%b flags=%b exp=0/1001", ovf_sticky, flags); end
  endtask

  task automatic test_reset_flush();
    rf_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'h00, 5'(i + 8), 32'h0, 32'(i + 1), 4'b0000); step();
    end
    idle();
    total++; if (count !== 3'd3) begin bad++; $display("FAIL pre_flush got=%0d exp=3", count); end
    #1 reset = 1'b1;
    #1;
    total++; if (count !== 3'd0 || wr_en !== 1'b0 || wr_data !== 32'h0 || HI !== 32'h0 || flags !== 4'h0) begin
      bad++; $display("FAIL async_flush count=%0d wr_en=%b data=%h HI=%h flags=%b exp=0/0/0/0/0", count, wr_en, wr_data, HI, flags); end
    #1 reset = 1'b0;
    step();
    total++; if (count !== 3'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL post_flush count=%0d in_ready=%b exp=0/1", count, in_ready); end
  endtask

  initial begin
    test_reset();
    test_mult_div();
    test_fill_drain();
    test_back_to_back();
    test_dest0();
    test_ovf();
    test_reset_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
